vgpr_wr_arbiter: RTL

- Write-port front end for the 64-lane, 1024x32b vector register file. The register file has one write port.
- Merges write-back traffic from the SIMD ALU and from the LSU load-return path into that single port.
- Each source has a small FIFO. Sources are served round-robin. Each request is sanitised, then presented to the register file as one registered write per cycle (wr0_addr / wr0_en / wr0_en_xoutof4 / wr0_data).

---
 rtl/vgpr_wr_arbiter_pkg.sv | 29 ++
 rtl/vgpr_wr_arbiter_fifo.sv | 46 ++++
 rtl/vgpr_wr_arbiter.sv | 128 ++++++++++++
 3 files changed

// File: rtl/vgpr_wr_arbiter_pkg.sv
// Shared definitions for the VGPR write-port arbiter.
// Request record layout and the dword range helper.
package vgpr_wr_arbiter_pkg;

   localparam int VGPR_ADDR_W   = 10;
   localparam int VGPR_LANES    = 64;
   localparam int VGPR_DATA_W   = 2048;
   localparam int VGPR_MAX_ADDR = 1023;

   typedef struct packed {
      logic [VGPR_ADDR_W-1:0] addr;
      logic [VGPR_LANES-1:0]  lane_en;
      logic [3:0]             xoutof4;
      logic [VGPR_DATA_W-1:0] data;
   } vgpr_req_t;

   // Bit k set when addr+k still lies inside the register file.
   function automatic logic [3:0] legal_dwords(
      input logic [VGPR_ADDR_W-1:0] addr
   );
      logic [3:0] m;
      m = '0;
      for (int k = 0; k < 4; k++) begin
         m[k] = ({1'b0, addr} + 11'(k)) <= 11'(VGPR_MAX_ADDR);
      end
      return m;
   endfunction

endpackage

// File: rtl/vgpr_wr_arbiter_fifo.sv
// Small synchronous FIFO holding pending register writes.
// Pointers carry one wrap bit so full/empty need no extra state.
module vgpr_wr_fifo #(
   parameter int DEPTH = 2,
   parameter int W     = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push,
   input  logic [W-1:0]           din,
   input  logic                   pop,
   output logic [W-1:0]           dout,
   output logic [$clog2(DEPTH):0] count,
   output logic                   full,
   output logic                   empty
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]  wptr;
   logic [AW:0]  rptr;
   logic [W-1:0] mem [DEPTH];

   // Advance read/write pointers; reset empties the FIFO.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (push) wptr <= wptr + {{AW{1'b0}}, 1'b1};
         if (pop)  rptr <= rptr + {{AW{1'b0}}, 1'b1};
      end
   end

   // Storage needs no reset; pointers define validity.
   always_ff @(posedge clk) begin
      if (push) mem[wptr[AW-1:0]] <= din;
   end

   assign dout  = mem[rptr[AW-1:0]];
   assign count = wptr - rptr;
   assign empty = (wptr == rptr);
   assign full  = (wptr[AW] != rptr[AW]) &&
                  (wptr[AW-1:0] == rptr[AW-1:0]);

endmodule

// File: rtl/vgpr_wr_arbiter.sv
// VGPR write-port arbiter: ALU and LSU write-back merged
// round-robin onto the single register-file write port.
module vgpr_wr_arbiter
   import vgpr_wr_arbiter_pkg::*;
#(
   parameter int FIFO_DEPTH = 2,
   parameter int ADDR_W     = 10,
   parameter int LANES      = 64,
   parameter int DATA_W     = 2048
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              alu_wr_valid,
   output logic              alu_wr_ready,
   input  logic [ADDR_W-1:0] alu_wr_addr,
   input  logic [LANES-1:0]  alu_wr_lane_en,
   input  logic [3:0]        alu_wr_xoutof4,
   input  logic [DATA_W-1:0] alu_wr_data,
   input  logic              lsu_wr_valid,
   output logic              lsu_wr_ready,
   input  logic [ADDR_W-1:0] lsu_wr_addr,
   input  logic [LANES-1:0]  lsu_wr_lane_en,
   input  logic [3:0]        lsu_wr_xoutof4,
   input  logic [DATA_W-1:0] lsu_wr_data,
   output logic [ADDR_W-1:0] wr0_addr,
   output logic [LANES-1:0]  wr0_en,
   output logic [3:0]        wr0_en_xoutof4,
   output logic [DATA_W-1:0] wr0_data,
   output logic              busy,
   output logic              addr_err
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam int RW = $bits(vgpr_req_t);

   vgpr_req_t alu_req, lsu_req, alu_head, lsu_head, head;
   logic alu_fire, lsu_fire, alu_push, lsu_push;
   logic alu_bad, lsu_bad;
   logic alu_full, lsu_full, alu_empty, lsu_empty;
   logic alu_gnt, lsu_gnt, rr_lsu;
   logic [CW-1:0] alu_count, lsu_count;

   assign alu_wr_ready = !alu_full;
   assign lsu_wr_ready = !lsu_full;
   assign alu_fire = alu_wr_valid & alu_wr_ready;
   assign lsu_fire = lsu_wr_valid & lsu_wr_ready;

   // Clear dword enables that run past the top of the file.
   always_comb begin
      alu_req.addr    = alu_wr_addr;
      alu_req.lane_en = alu_wr_lane_en;
      alu_req.xoutof4 = alu_wr_xoutof4 & legal_dwords(alu_wr_addr);
      alu_req.data    = alu_wr_data;
      lsu_req.addr    = lsu_wr_addr;
      lsu_req.lane_en = lsu_wr_lane_en;
      lsu_req.xoutof4 = lsu_wr_xoutof4 & legal_dwords(lsu_wr_addr);
      lsu_req.data    = lsu_wr_data;
   end

   assign alu_bad  = alu_wr_xoutof4 != alu_req.xoutof4;
   assign lsu_bad  = lsu_wr_xoutof4 != lsu_req.xoutof4;
   assign alu_push = alu_fire & (|alu_req.lane_en) & (|alu_req.xoutof4);
   assign lsu_push = lsu_fire & (|lsu_req.lane_en) & (|lsu_req.xoutof4);

   vgpr_wr_fifo #(.DEPTH(FIFO_DEPTH), .W(RW)) u_alu_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (alu_push),
      .din   (alu_req),
      .pop   (alu_gnt),
      .dout  (alu_head),
      .count (alu_count),
      .full  (alu_full),
      .empty (alu_empty)
   );

   vgpr_wr_fifo #(.DEPTH(FIFO_DEPTH), .W(RW)) u_lsu_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (lsu_push),
      .din   (lsu_req),
      .pop   (lsu_gnt),
      .dout  (lsu_head),
      .count (lsu_count),
      .full  (lsu_full),
      .empty (lsu_empty)
   );

   assign alu_gnt = !alu_empty && (lsu_empty || !rr_lsu);
   assign lsu_gnt = !lsu_empty && !alu_gnt;
   assign head    = alu_gnt ? alu_head : lsu_head;

   // Round-robin: priority flips to the source not just served.
   always_ff @(posedge clk) begin
      if (!rst_n)       rr_lsu <= 1'b0;
      else if (alu_gnt) rr_lsu <= 1'b1;
      else if (lsu_gnt) rr_lsu <= 1'b0;
   end

   // Register the granted write; idle cycles drop the enables.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr0_addr       <= '0;
         wr0_en         <= '0;
         wr0_en_xoutof4 <= '0;
         wr0_data       <= '0;
      end else if (alu_gnt || lsu_gnt) begin
         wr0_addr       <= head.addr;
         wr0_en         <= head.lane_en;
         wr0_en_xoutof4 <= head.xoutof4;
         wr0_data       <= head.data;
      end else begin
         wr0_en         <= '0;
         wr0_en_xoutof4 <= '0;
      end
   end

   // Sticky out-of-range flag, cleared only by reset.
   always_ff @(posedge clk) begin
      if (!rst_n)
         addr_err <= 1'b0;
      else if ((alu_fire && alu_bad) || (lsu_fire && lsu_bad))
         addr_err <= 1'b1;
   end

   assign busy = (|alu_count) | (|lsu_count) | (|wr0_en);

endmodule
